// File: rtl/des_key_pkg.sv
// Shared DES key-schedule constants: rotation schedule, PC-2 selection table,
// sequencer states and 28-bit half rotations.
package des_key_pkg;

    typedef enum logic {IDLE = 1'b0, ROUND = 1'b1} state_e;

    localparam logic [1:0] SHIFTS [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // 1-based FIPS numbering: entry 1 is the MSB of {C,D}, entry 0 is the subkey MSB
    localparam logic [5:0] PC2 [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
        6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
        6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
        6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
        6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    rotl28 = {x[26:0], x[27]};
            2'd2:    rotl28 = {x[25:0], x[27:26]};
            default: rotl28 = x;
        endcase
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    rotr28 = {x[0], x[27:1]};
            2'd2:    rotr28 = {x[1:0], x[27:2]};
            default: rotr28 = x;
        endcase
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2: selects 48 of the 56 {C,D} bits to form a round subkey.
module des_pc2
    import des_key_pkg::*;
(
    input  logic [55:0] cd_i,
    output logic [47:0] subkey_o
);

    for (genvar j = 0; j < 48; j++) begin : g_sel
        assign subkey_o[47-j] = cd_i[56 - int'(PC2[j])];
    end

endmodule

// File: rtl/des_key_sched_ctrl.sv
// Handshaked DES key-schedule sequencer: latches a PC-1 key, walks C/D through
// the shift schedule in encrypt or decrypt order and emits one subkey per handshake.
module des_key_sched_ctrl
    import des_key_pkg::*;
#(
    parameter int ROUNDS   = 16,
    parameter int KEY_W    = 56,
    parameter int SUBKEY_W = 48
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_W-1:0]    key_in,
    input  logic                decrypt,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic                abort,
    output logic [SUBKEY_W-1:0] subkey,
    output logic                subkey_valid,
    input  logic                subkey_ready,
    output logic [3:0]          round_idx,
    output logic                subkey_last,
    output logic                busy,
    output logic                done
);

    if (ROUNDS != 16 || KEY_W != 56 || SUBKEY_W != 48) begin : g_bad_param
        $error("des_key_sched_ctrl: DES requires ROUNDS=16, KEY_W=56, SUBKEY_W=48");
    end

    state_e      state_q;
    logic [27:0] c_q, d_q;
    logic [3:0]  round_q;
    logic        mode_q;
    logic        done_q;
    logic [1:0]  enc_sh, dec_sh;

    // Amount applied on the handshake that leaves round round_q
    assign enc_sh = SHIFTS[round_q + 4'd1];
    assign dec_sh = SHIFTS[4'd15 - round_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (key_valid) begin
                        mode_q  <= decrypt;
                        round_q <= '0;
                        state_q <= ROUND;
                        // Decrypt starts at K16: cumulative rotation 28 is the identity
                        c_q <= decrypt ? key_in[55:28] : rotl28(key_in[55:28], SHIFTS[0]);
                        d_q <= decrypt ? key_in[27:0]  : rotl28(key_in[27:0],  SHIFTS[0]);
                    end
                end
                ROUND: begin
                    if (abort) begin
                        state_q <= IDLE;
                        c_q     <= '0;
                        d_q     <= '0;
                        round_q <= '0;
                    end else if (subkey_ready) begin
                        if (round_q == 4'd15) begin
                            state_q <= IDLE;
                            c_q     <= '0;
                            d_q     <= '0;
                            round_q <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            c_q     <= mode_q ? rotr28(c_q, dec_sh) : rotl28(c_q, enc_sh);
                            d_q     <= mode_q ? rotr28(d_q, dec_sh) : rotl28(d_q, enc_sh);
                            round_q <= round_q + 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    des_pc2 u_pc2 (
        .cd_i     ({c_q, d_q}),
        .subkey_o (subkey)
    );

    assign key_ready    = (state_q == IDLE);
    assign subkey_valid = (state_q == ROUND);
    assign busy         = (state_q == ROUND);
    assign round_idx    = round_q;
    assign subkey_last  = subkey_valid && (round_q == 4'd15);
    assign done         = done_q;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Directed bench for des_key_sched_ctrl using the FIPS worked-example key.
module tb_des_key_sched_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [55:0] key_in;
    logic        decrypt, key_valid, key_ready, abort;
    logic [47:0] subkey;
    logic        subkey_valid, subkey_ready;
    logic [3:0]  round_idx;
    logic        subkey_last, busy, done;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [55:0] KEY  = 56'hF0CCAAF556678F;
    localparam logic [55:0] KEY2 = 56'h123456789ABCDE;

    // K1..K16 of the worked example
    logic [47:0] ENC [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    des_key_sched_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .decrypt      (decrypt),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .abort        (abort),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round_idx    (round_idx),
        .subkey_last  (subkey_last),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_key(input logic [55:0] k, input logic dec);
        key_in    = k;
        decrypt   = dec;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic chk_round(input int i, input logic [47:0] exp);
        chk($sformatf("subkey[%0d]", i), 64'(subkey), 64'(exp));
        chk($sformatf("round_idx[%0d]", i), 64'(round_idx), 64'(i));
        chk($sformatf("valid[%0d]", i), 64'(subkey_valid), 64'd1);
        chk($sformatf("last[%0d]", i), 64'(subkey_last), 64'(i == 15));
    endtask

    task automatic chk_done();
        chk("done_pulse", 64'(done), 64'd1);
        chk("idle_key_ready", 64'(key_ready), 64'd1);
        chk("idle_valid", 64'(subkey_valid), 64'd0);
        tick();
        chk("done_clear", 64'(done), 64'd0);
    endtask

    initial begin
        rst = 1'b1; key_in = '0; decrypt = 1'b0; key_valid = 1'b0;
        abort = 1'b0; subkey_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_key_ready", 64'(key_ready), 64'd1);
        chk("rst_valid", 64'(subkey_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_round", 64'(round_idx), 64'd0);
        chk("rst_subkey", 64'(subkey), 64'd0);

        // Encrypt, back-to-back
        start_key(KEY, 1'b0);
        chk("enc_busy", 64'(busy), 64'd1);
        chk("enc_key_ready", 64'(key_ready), 64'd0);
        for (int i = 0; i < 16; i++) begin
            chk_round(i, ENC[i]);
            tick();
        end
        chk_done();

        // Decrypt, back-to-back
        start_key(KEY, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk_round(i, ENC[15-i]);
            tick();
        end
        chk_done();

        // Stall 5 cycles at round 3
        start_key(KEY, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk_round(i, ENC[i]);
            if (i == 3) begin
                subkey_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk("stall_subkey", 64'(subkey), 64'(ENC[3]));
                    chk("stall_round", 64'(round_idx), 64'd3);
                    chk("stall_last", 64'(subkey_last), 64'd0);
                end
                subkey_ready = 1'b1;
            end
            tick();
        end
        chk_done();

        // Abort at round 7 together with a handshake
        start_key(KEY, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        chk("pre_abort_round", 64'(round_idx), 64'd7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_key_ready", 64'(key_ready), 64'd1);
        chk("abort_valid", 64'(subkey_valid), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_round", 64'(round_idx), 64'd0);
        chk("abort_c", 64'(dut.c_q), 64'd0);
        chk("abort_d", 64'(dut.d_q), 64'd0);
        chk("abort_subkey", 64'(subkey), 64'd0);
        tick();
        chk("abort_no_done", 64'(done), 64'd0);

        // New key after abort, then reset at round 10
        start_key(KEY, 1'b0);
        chk("post_abort_k1", 64'(subkey), 64'(ENC[0]));
        for (int i = 0; i < 10; i++) tick();
        chk("pre_rst_round", 64'(round_idx), 64'd10);
        chk("pre_rst_subkey", 64'(subkey), 64'(ENC[10]));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", 64'(subkey_valid), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_key_ready", 64'(key_ready), 64'd1);
        chk("mrst_round", 64'(round_idx), 64'd0);

        // A second key offered while busy is ignored
        start_key(KEY, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk_round(i, ENC[i]);
            if (i == 5) begin
                key_in = KEY2; decrypt = 1'b1; key_valid = 1'b1;
            end
            tick();
            key_valid = 1'b0;
        end
        chk_done();

        // abort in IDLE does not block a same-cycle key
        abort = 1'b1;
        start_key(KEY, 1'b1);
        abort = 1'b0;
        chk("idle_abort_busy", 64'(busy), 64'd1);
        chk("idle_abort_subkey", 64'(subkey), 64'(ENC[15]));
        tick();
        chk("idle_abort_k15", 64'(subkey), 64'(ENC[14]));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("final_idle", 64'(key_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/des_key_sched_ctrl.md
Name: des_key_sched_ctrl

Overview:
- Sequencer for the 56-bit key register in the DES-AES core: owns the key, generates the 16 DES round subkeys in order, and hands them to the DES round datapath one per handshake.
- Takes a PC-1-permuted 56-bit key and a mode bit. Rotates the C/D halves per the DES shift schedule: left for encrypt, right for decrypt. Emits PC-2(C,D) with a valid/ready handshake.
- Zeroises key state after the last round or on abort.
- Sits between the key-input interface and the DES round engine. Replaces free-running key shifting with an explicitly sequenced, handshaked schedule.

Parameters:
- ROUNDS, 16, number of subkeys emitted per key. Fixed to 16 for DES; any other value is an elaboration error.
- KEY_W, 56, width of the PC-1-permuted key input.
- SUBKEY_W, 48, width of the PC-2 subkey output.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- key_in  input  56  PC-1-permuted key; C0=key_in[55:28], D0=key_in[27:0].
- decrypt  input  1  sampled with key_in; 1=decrypt order (K16..K1), 0=encrypt order (K1..K16).
- key_valid  input  1  key_in/decrypt valid.
- key_ready  output  1  high only in IDLE.
- abort  input  1  synchronous abandon of the current schedule.
- subkey  output  48  PC-2(C,D) of the current round.
- subkey_valid  output  1  subkey valid.
- subkey_ready  input  1  consumer accepts the subkey.
- round_idx  output  4  0-based emitted-round index (0..15).
- subkey_last  output  1  high with subkey_valid when round_idx==15.
- busy  output  1  high in ROUND state.
- done  output  1  one-cycle pulse after the final subkey handshake.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; C,D,round_idx,mode=0.
  - subkey_valid=0, done=0, busy=0, key_ready=1 from the next cycle.
  - rst has priority over all other inputs.
- Shift table SHIFTS[0..15] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- IDLE, key accept (key_valid & key_ready):
  - Latch mode=decrypt. Set round_idx=0. Go to ROUND.
  - Encrypt: C,D = rotl(C0,SHIFTS[0]), rotl(D0,SHIFTS[0]).
  - Decrypt: C,D = C0,D0 unrotated (total rotation 28 is the identity, giving K16).
- ROUND state:
  - subkey_valid=1, busy=1, key_ready=0.
  - subkey is combinational PC-2 of the registered {C,D}.
  - First subkey_valid appears the cycle after key accept (latency 1).
- Subkey handshake (subkey_valid & subkey_ready) at round i:
  - i<15, encrypt: rotate left by SHIFTS[i+1]; round_idx=i+1.
  - i<15, decrypt: rotate right by SHIFTS[15-i]; round_idx=i+1.
  - i==15: go to IDLE, clear C,D and round_idx to 0, pulse done for one cycle.
- Back-to-back throughput: one subkey per cycle while subkey_ready is held high.
- Stall: while subkey_valid & !subkey_ready, subkey, round_idx and subkey_last hold stable.
- key_valid in ROUND is ignored; no key is accepted until back in IDLE. A new key is accepted earliest the cycle after the last handshake (the cycle done is high).
- abort=1 in ROUND:
  - Next state IDLE, C,D,round_idx cleared, subkey_valid=0, no done pulse.
  - abort beats a same-cycle subkey handshake: the handshake is not counted.
- abort=1 in IDLE has no effect. A key_valid in the same cycle as abort in IDLE is still accepted.
- Rotations are modulo 28 within each half; C and D never mix.
- In IDLE, the subkey output drives PC-2(0,0)=0.

Decomposition:
- Package des_key_pkg holds:
  - SHIFTS table (16 x 2-bit).
  - PC2 table (48 entries of 6-bit source index into the 56-bit {C,D}).
  - state enum {IDLE, ROUND}.
  - rotl28/rotr28 functions.
- One sub-module, des_pc2: purely combinational 56-to-48 PC-2 permutation, reusable by the round engine tests.

Test Plan:
- Encrypt known vector: key_in=56'hF0CCAAF556678F, decrypt=0, subkey_ready=1. Required:
  - subkey_valid the cycle after accept.
  - K1=48'h1B02EFFC7072, K2=48'h79AED9DBC9E5, K16=48'hCB3D8B0E17F5.
  - 16 consecutive cycles, subkey_last on round_idx 15, done the following cycle.
- Decrypt same key: first subkey=48'hCB3D8B0E17F5 (round_idx 0), second = the encrypt K15 value, last=48'h1B02EFFC7072.
- Stall: drop subkey_ready for 5 cycles at round_idx 3 -> subkey, round_idx stable; resume -> the remaining sequence is identical to the no-stall run.
- Abort at round_idx 7 with subkey_ready=1 in the same cycle -> next cycle IDLE, key_ready=1, no done pulse, internal C,D=0. A new key then yields the correct K1.
- Key while busy: pulse key_valid with a different key during ROUND -> ignored, the original schedule completes unchanged.
- Reset mid-schedule at round_idx 10 -> next cycle subkey_valid=0, busy=0, key_ready=1, round_idx=0.
